// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave to simple req/ack register bus bridge, one access in flight.
// Optional register-side timeout compiled in with `define AXIL_REG_TIMEOUT_EN.
module axi4lite_reg_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic                    reg_ack,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  rdy_q;
  logic                  prio_rd_q, prio_rd_d;
  logic                  cur_we_q, cur_we_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  reg_req_q, reg_req_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]     reg_wstrb_q, reg_wstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tmo_hit;

`ifdef AXIL_REG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = reg_req_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_IDLE)
      tmo_d = '0;
    else if (state_q == S_ACCESS && reg_req_q && !reg_ack)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  // Ready is gated by rdy_q so nothing is accepted until the cycle after reset.
  assign AWREADY   = rdy_q & ~aw_full_q;
  assign WREADY    = rdy_q & ~w_full_q;
  assign ARREADY   = rdy_q & ~ar_full_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign RVALID    = rvalid_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;
  assign reg_req   = reg_req_q;
  assign reg_we    = cur_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wstrb = reg_wstrb_q;

  logic wr_pend, rd_pend, grant_wr, done, done_err;

  always_comb begin
    state_d     = state_q;
    prio_rd_d   = prio_rd_q;
    cur_we_d    = cur_we_q;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    ar_full_d   = ar_full_q;
    ar_addr_d   = ar_addr_q;
    reg_req_d   = reg_req_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wstrb_d = reg_wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    wr_pend     = aw_full_q & w_full_q;
    rd_pend     = ar_full_q;
    grant_wr    = wr_pend & (~rd_pend | ~prio_rd_q);
    done        = 1'b0;
    done_err    = 1'b0;

    if (AWVALID && AWREADY) begin
      aw_full_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && WREADY) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (ARVALID && ARREADY) begin
      ar_full_d = 1'b1;
      ar_addr_d = ARADDR;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_pend || rd_pend) begin
          state_d     = S_ACCESS;
          reg_req_d   = 1'b1;
          cur_we_d    = grant_wr;
          prio_rd_d   = grant_wr;
          reg_addr_d  = (grant_wr ? aw_addr_q : ar_addr_q) & ALIGN_MASK;
          reg_wdata_d = grant_wr ? w_data_q : '0;
          reg_wstrb_d = grant_wr ? w_strb_q : '0;
        end
      end
      S_ACCESS: begin
        if (reg_req_q && reg_ack) begin
          done     = 1'b1;
          done_err = reg_err;
        end else if (tmo_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
        if (done) begin
          reg_req_d = 1'b0;
          state_d   = S_RESP;
          if (cur_we_q) begin
            bvalid_d = 1'b1;
            bresp_d  = done_err ? 2'b10 : 2'b00;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = done_err ? 2'b10 : 2'b00;
            rdata_d  = done_err ? '0 : reg_rdata;
          end
        end
      end
      S_RESP: begin
        if (cur_we_q && bvalid_q && BREADY) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = S_IDLE;
        end else if (!cur_we_q && rvalid_q && RREADY) begin
          rvalid_d  = 1'b0;
          ar_full_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      prio_rd_q   <= 1'b0;
      cur_we_q    <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      ar_full_q   <= 1'b0;
      ar_addr_q   <= '0;
      reg_req_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      prio_rd_q   <= prio_rd_d;
      cur_we_q    <= cur_we_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      ar_full_q   <= ar_full_d;
      ar_addr_q   <= ar_addr_d;
      reg_req_q   <= reg_req_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wstrb_q <= reg_wstrb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Directed bench for axi4lite_reg_bridge: writes, reads, arbitration, reset, timeout.
module tb_axi4lite_reg_bridge;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  WSTRB, reg_wstrb;
  logic [1:0]  BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        reg_req, reg_we, reg_ack, reg_err;

  int total = 0;
  int bad   = 0;

  logic        g_we;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_wstrb;

  always #5 ACLK = ~ACLK;

  axi4lite_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic do_w, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic do_r, input logic [31:0] ra);
    AWADDR = wa; WDATA = wd; WSTRB = ws; ARADDR = ra;
    AWVALID = do_w; WVALID = do_w; ARVALID = do_r;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
  endtask

  // Register-side responder: wait for req, hold off dly cycles, then ack once.
  task automatic reg_serve(input int dly, input logic [31:0] rd, input logic er,
                           output logic we, output logic [31:0] ad,
                           output logic [31:0] wd, output logic [3:0] ws);
    int n = 0;
    while (!reg_req && n < 50) begin tick(); n++; end
    chk("req_seen", reg_req, 1);
    we = reg_we; ad = reg_addr; wd = reg_wdata; ws = reg_wstrb;
    repeat (dly) tick();
    chk("req_stable", {reg_req, reg_addr}, {1'b1, ad});
    reg_rdata = rd; reg_err = er; reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    chk("req_drop", reg_req, 0);
  endtask

  task automatic wait_b(input logic [1:0] exp);
    int n = 0;
    while (!BVALID && n < 50) begin tick(); n++; end
    chk("bvalid", BVALID, 1);
    chk("bresp", BRESP, exp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_clr", BVALID, 0);
  endtask

  task automatic wait_r(input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n = 0;
    while (!RVALID && n < 50) begin tick(); n++; end
    chk("rvalid", RVALID, 1);
    chk("rresp", RRESP, exp_r);
    chk("rdata", RDATA, exp_d);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("rvalid_clr", RVALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0; reg_ack = 0; reg_rdata = '0; reg_err = 0;
    repeat (2) tick();
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_resp", {BVALID, RVALID, reg_req}, 3'b000);
    ARESET = 1'b0;
    tick();
    chk("ready_up", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Write with unaligned address, ack after two cycles
    send(1, 32'h0000_0013, 32'hDEAD_BEEF, 4'hF, 0, '0);
    chk("aw_held", {AWREADY, WREADY}, 2'b00);
    reg_serve(2, '0, 0, g_we, g_addr, g_wdata, g_wstrb);
    chk("w1_addr", g_addr, 32'h10);
    chk("w1_we", g_we, 1);
    chk("w1_data", {g_wdata, g_wstrb}, {32'hDEAD_BEEF, 4'hF});
    wait_b(2'b00);
    chk("aw_free", {AWREADY, WREADY}, 2'b11);

    // Write with error and partial strobes
    send(1, 32'h0000_000A, 32'h0000_FFFF, 4'h5, 0, '0);
    reg_serve(0, '0, 1, g_we, g_addr, g_wdata, g_wstrb);
    chk("w2_addr", g_addr, 32'h08);
    chk("w2_strb", g_wstrb, 4'h5);
    wait_b(2'b10);

    // Read with error -> RDATA forced to zero
    send(0, '0, '0, '0, 1, 32'h24);
    reg_serve(0, 32'h1234_5678, 1, g_we, g_addr, g_wdata, g_wstrb);
    chk("r1_addr", {g_we, g_addr}, {1'b0, 32'h24});
    wait_r(32'h0, 2'b10);

    // Good read
    send(0, '0, '0, '0, 1, 32'h3B);
    reg_serve(1, 32'hCAFE_0001, 0, g_we, g_addr, g_wdata, g_wstrb);
    chk("r2_addr", g_addr, 32'h38);
    wait_r(32'hCAFE_0001, 2'b00);

    // Write pair and read pending together, twice
    for (int k = 0; k < 2; k++) begin
      send(1, 32'h100 + k*4, 32'h1111_1111 * (k+1), 4'hF, 1, 32'h200 + k*4);
      reg_serve(0, '0, 0, g_we, g_addr, g_wdata, g_wstrb);
      chk("arb_wr", {g_we, g_addr}, {1'b1, 32'h100 + k*4});
      wait_b(2'b00);
      reg_serve(0, 32'hA0 + k, 0, g_we, g_addr, g_wdata, g_wstrb);
      chk("arb_rd", {g_we, g_addr}, {1'b0, 32'h200 + k*4});
      wait_r(32'hA0 + k, 2'b00);
    end

    // W three cycles ahead of AW, slow BREADY
    WDATA = 32'hA5A5_A5A5; WSTRB = 4'h3; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("w_only_held", {WREADY, AWREADY}, 2'b01);
    repeat (2) tick();
    chk("w_only_noreq", reg_req, 0);
    AWADDR = 32'h44; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    reg_serve(1, '0, 0, g_we, g_addr, g_wdata, g_wstrb);
    chk("late_aw", {g_we, g_addr, g_wdata, g_wstrb}, {1'b1, 32'h44, 32'hA5A5_A5A5, 4'h3});
    repeat (4) tick();
    chk("b_held", {BVALID, reg_req}, 2'b10);
    wait_b(2'b00);

    // Reset while a read access is outstanding
    begin
      int n = 0;
      logic seen;
      send(0, '0, '0, '0, 1, 32'h50);
      while (!reg_req && n < 50) begin tick(); n++; end
      chk("rst_req_up", reg_req, 1);
      #2 ARESET = 1'b1;
      #1;
      chk("rst_now", {reg_req, ARREADY, AWREADY, WREADY, reg_addr}, '0);
      tick();
      ARESET = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen |= RVALID | BVALID | reg_req;
      end
      chk("rst_no_resp", seen, 0);
      chk("rst_ready_back", ARREADY, 1);
    end

    // First arbitration after reset grants write
    send(1, 32'h80, 32'h0BAD_F00D, 4'hC, 1, 32'h90);
    reg_serve(0, '0, 0, g_we, g_addr, g_wdata, g_wstrb);
    chk("post_rst_wr", {g_we, g_addr}, {1'b1, 32'h80});
    wait_b(2'b00);
    reg_serve(0, 32'h77, 0, g_we, g_addr, g_wdata, g_wstrb);
    chk("post_rst_rd", {g_we, g_addr}, {1'b0, 32'h90});
    wait_r(32'h77, 2'b00);

`ifdef AXIL_REG_TIMEOUT_EN
    begin
      int n = 0;
      int hi = 0;
      send(0, '0, '0, '0, 1, 32'h60);
      while (!reg_req && n < 50) begin tick(); n++; end
      while (reg_req && hi < 50) begin hi++; tick(); end
      chk("tmo_cycles", hi, 8);
      wait_r(32'h0, 2'b10);
    end
`else
    begin
      int n = 0;
      send(0, '0, '0, '0, 1, 32'h60);
      while (!reg_req && n < 50) begin tick(); n++; end
      repeat (20) tick();
      chk("no_tmo_wait", {reg_req, RVALID}, 2'b10);
      reg_serve(0, 32'h55, 0, g_we, g_addr, g_wdata, g_wstrb);
      wait_r(32'h55, 2'b00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
